// File: rtl/alu_exec_stage.sv
// Execute stage behind the switch/LED front end: synchronises the switches, debounces the
// execute button, and runs one 8-bit ALU operation per press (multiply is shift-add, 8 cycles).
module alu_exec_stage #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] switches,
   input  logic        btn_exec,
   output logic [7:0]  reg_a,
   output logic [7:0]  reg_b,
   output logic [7:0]  reg_op,
   output logic [7:0]  alu_result,
   output logic        flag_c,
   output logic        flag_v,
   output logic        flag_z,
   output logic        flag_err,
   output logic        busy,
   output logic        result_valid
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, EXEC, DONE, WAIT_REL} state_t;

   state_t         state, state_nx;
   logic [23:0]    sw_s1, sw_s2;
   logic           btn_s1, btn_s2, btn_db, btn_db_q;
   logic [CW-1:0]  db_cnt;
   logic           press;
   logic [2:0]     mul_cnt;
   logic [15:0]    mul_acc, mul_addend, mul_next;
   logic           mul_busy;
   logic [8:0]     sum;
   logic [7:0]     res;
   logic           c, v, err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         sw_s1  <= switches;
         sw_s2  <= sw_s1;
         btn_s1 <= btn_exec;
         btn_s2 <= btn_s1;
      end
   end

   // Counter runs only while the synced level disagrees with btn_db; any agreement restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
      end else begin
         btn_db_q <= btn_db;
         if (btn_s2 != btn_db) begin
            if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               btn_db <= btn_s2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign press    = btn_db & ~btn_db_q;
   assign mul_busy = (reg_op == 8'h08) && (mul_cnt != 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (press) state_nx = LOAD;
         LOAD:     state_nx = EXEC;
         EXEC:     if (!mul_busy) state_nx = DONE;
         DONE:     state_nx = WAIT_REL;
         WAIT_REL: if (!btn_db) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   assign busy         = (state == LOAD) || (state == EXEC);
   assign result_valid = (state == DONE);

   always_comb begin
      res        = '0;
      c          = 1'b0;
      v          = 1'b0;
      err        = 1'b0;
      sum        = '0;
      mul_addend = reg_b[mul_cnt] ? ({8'h00, reg_a} << mul_cnt) : '0;
      mul_next   = mul_acc + mul_addend;
      case (reg_op)
         8'h00: begin
            sum = {1'b0, reg_a} + {1'b0, reg_b};
            res = sum[7:0];
            c   = sum[8];
            v   = (reg_a[7] == reg_b[7]) && (res[7] != reg_a[7]);
         end
         8'h01: begin
            sum = {1'b0, reg_a} - {1'b0, reg_b};
            res = sum[7:0];
            c   = sum[8];
            v   = (reg_a[7] != reg_b[7]) && (res[7] != reg_a[7]);
         end
         8'h02: res = reg_a & reg_b;
         8'h03: res = reg_a | reg_b;
         8'h04: res = reg_a ^ reg_b;
         8'h05: res = ~reg_a;
         8'h06: begin
            res = {reg_a[6:0], 1'b0};
            c   = reg_a[7];
         end
         8'h07: begin
            res = {1'b0, reg_a[7:1]};
            c   = reg_a[0];
         end
         8'h08: begin
            res = mul_next[7:0];
            c   = |mul_next[15:8];
         end
         default: err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_a      <= '0;
         reg_b      <= '0;
         reg_op     <= '0;
         alu_result <= '0;
         flag_c     <= 1'b0;
         flag_v     <= 1'b0;
         flag_z     <= 1'b0;
         flag_err   <= 1'b0;
         mul_acc    <= '0;
         mul_cnt    <= '0;
      end else begin
         if (state == LOAD) begin
            reg_a   <= sw_s2[7:0];
            reg_b   <= sw_s2[15:8];
            reg_op  <= sw_s2[23:16];
            mul_acc <= '0;
            mul_cnt <= '0;
         end
         if (state == EXEC) begin
            if (mul_busy) begin
               mul_acc <= mul_next;
               mul_cnt <= mul_cnt + 3'd1;
            end else begin
               alu_result <= res;
               flag_c     <= c;
               flag_v     <= v;
               flag_z     <= (res == 8'h00);
               flag_err   <= err;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a short debounce window: vector table plus
// bounce, hold, switch-stability and mid-multiply reset sequences.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] switches;
   logic        btn_exec;
   logic [7:0]  reg_a, reg_b, reg_op, alu_result;
   logic        flag_c, flag_v, flag_z, flag_err, busy, result_valid;

   int n_checks = 0;
   int n_fail   = 0;
   int rv_count = 0;

   alu_exec_stage #(.DEBOUNCE_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .switches(switches), .btn_exec(btn_exec),
      .reg_a(reg_a), .reg_b(reg_b), .reg_op(reg_op), .alu_result(alu_result),
      .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_err(flag_err),
      .busy(busy), .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (result_valid) rv_count++;

   typedef struct {
      logic [7:0] a, b, op, res;
      logic       c, v, z, err;
      int         lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Press and count negedges until result_valid; 21 = 16 debounce + 2 sync + 3 op cycles.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           output int lat);
      switches = {op, b, a};
      repeat (3) @(negedge clk);
      btn_exec = 1'b1;
      lat = 0;
      while (!result_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_btn();
      btn_exec = 1'b0;
      repeat (25) @(negedge clk);
   endtask

   task automatic chk_vec(input string tag, input vec_t t, input int lat);
      chk({tag, " latency"}, lat, t.lat);
      chk({tag, " result"}, alu_result, t.res);
      chk({tag, " flags cvze"}, {flag_c, flag_v, flag_z, flag_err}, {t.c, t.v, t.z, t.err});
      chk({tag, " regs"}, {reg_a, reg_b, reg_op}, {t.a, t.b, t.op});
   endtask

   initial begin
      int lat;
      int rv0;
      vecs[0]  = '{8'h7F, 8'h01, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 21};
      vecs[1]  = '{8'h05, 8'h07, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 21};
      vecs[2]  = '{8'h0F, 8'h11, 8'h08, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 28};
      vecs[3]  = '{8'h10, 8'h10, 8'h08, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 28};
      vecs[4]  = '{8'hAA, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 21};
      vecs[5]  = '{8'hF0, 8'h0F, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 21};
      vecs[6]  = '{8'hF0, 8'h0F, 8'h03, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 21};
      vecs[7]  = '{8'hAA, 8'hFF, 8'h04, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 21};
      vecs[8]  = '{8'h5A, 8'h00, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 21};
      vecs[9]  = '{8'h81, 8'h00, 8'h06, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 21};
      vecs[10] = '{8'h81, 8'h00, 8'h07, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 21};
      vecs[11] = '{8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 21};
      vecs[12] = '{8'h80, 8'h01, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 21};
      vecs[13] = '{8'hFF, 8'hFF, 8'h08, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 28};

      rst_n = 1'b0;
      btn_exec = 1'b0;
      switches = 24'h0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {reg_a, reg_b, reg_op, alu_result}, 32'h0);
      chk("reset status", {flag_c, flag_v, flag_z, flag_err, busy, result_valid}, 6'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         rv0 = rv_count;
         start_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
         @(negedge clk);
         chk_vec($sformatf("vec%0d", i), vecs[i], lat);
         chk($sformatf("vec%0d pulses", i), rv_count - rv0, 1);
         release_btn();
         chk($sformatf("vec%0d idle", i), busy, 1'b0);
      end

      // Bounce: 5-cycle pulses are shorter than the debounce window.
      switches = {8'h03, 8'h0C, 8'h30};
      rv0 = rv_count;
      for (int k = 0; k < 50; k++) begin
         btn_exec = 1'b1;
         repeat (5) @(negedge clk);
         btn_exec = 1'b0;
         repeat (5) @(negedge clk);
      end
      chk("bounce no op", rv_count - rv0, 0);
      chk("bounce no busy", busy, 1'b0);
      btn_exec = 1'b1;
      lat = 0;
      while (!result_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("bounce final latency", lat, 21);
      chk("bounce final result", alu_result, 8'h3C);
      // Held button: WAIT_REL must block a second operation.
      repeat (200) @(negedge clk);
      chk("hold single op", rv_count - rv0, 1);
      release_btn();

      // Switch change during multiply EXEC must not disturb the operation.
      rv0 = rv_count;
      switches = {8'h08, 8'h11, 8'h0F};
      repeat (3) @(negedge clk);
      btn_exec = 1'b1;
      repeat (23) @(negedge clk);
      chk("mul busy mid-exec", busy, 1'b1);
      switches = {8'h00, 8'h55, 8'hC3};
      lat = 23;
      while (!result_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("stable mul latency", lat, 28);
      chk("stable reg_a", reg_a, 8'h0F);
      chk("stable result", alu_result, 8'hFF);
      chk("stable flag_c", flag_c, 1'b0);
      release_btn();

      // Reset at T+5 of a multiply: everything clears and no result follows.
      switches = {8'h08, 8'h03, 8'h07};
      repeat (3) @(negedge clk);
      rv0 = rv_count;
      btn_exec = 1'b1;
      repeat (23) @(negedge clk);
      chk("pre-reset busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid-reset regs", {reg_a, reg_b, reg_op, alu_result}, 32'h0);
      chk("mid-reset status", {flag_c, flag_v, flag_z, flag_err, busy, result_valid}, 6'h0);
      btn_exec = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no pulse after abort", rv_count - rv0, 0);
      start_op(8'h07, 8'h03, 8'h08, lat);
      @(negedge clk);
      chk("post-reset latency", lat, 28);
      chk("post-reset result", alu_result, 8'h15);
      chk("post-reset pulses", rv_count - rv0, 1);
      release_btn();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
